// File: rtl/data_mem_pkg.sv
// data_mem_pkg -- shared definitions for the data memory.
//   DEPTH_DEFAULT  default number of 32-bit words
//   DATA_W         data width
//   access_size_e  access size encoding (byte / half / word)
//   PRELOAD_WORD0/1 contents loaded into words 0 and 1 at reset when
//                  DATA_MEM_PRELOAD_EN is defined
//   decode_size()  maps the ByteOperation/HalfOperation flags to a size
package data_mem_pkg;

    localparam int DEPTH_DEFAULT = 64;
    localparam int DATA_W        = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    localparam logic [DATA_W-1:0] PRELOAD_WORD0 = 32'h807F_0201;
    localparam logic [DATA_W-1:0] PRELOAD_WORD1 = 32'hF00D_1234;

    // Byte wins over half when both flags are set.
    function automatic access_size_e decode_size(input logic byte_op, input logic half_op);
        if (byte_op)      return SIZE_BYTE;
        else if (half_op) return SIZE_HALF;
        else              return SIZE_WORD;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// data_mem_if -- load/store bus between a requester and data_mem.
//   addr          byte address
//   MemWrite      store enable
//   MemRead       load enable
//   HalfOperation halfword access
//   ByteOperation byte access
//   data_write    store data
//   data_read     load result
// Modports: master (requester), slave (memory).
interface data_mem_if;
    logic [31:0] addr;
    logic        MemWrite;
    logic        MemRead;
    logic        HalfOperation;
    logic        ByteOperation;
    logic [31:0] data_write;
    logic [31:0] data_read;

    modport master (
        output addr, MemWrite, MemRead, HalfOperation, ByteOperation, data_write,
        input  data_read
    );

    modport slave (
        input  addr, MemWrite, MemRead, HalfOperation, ByteOperation, data_write,
        output data_read
    );
endinterface

// File: rtl/data_mem_lane.sv
// data_mem_lane -- little-endian lane steering for data_mem.
//   size       access size
//   addr_lo    addr[1:0]
//   wdata      raw store data (low 8/16 bits used for byte/half)
//   rword      word currently held at the indexed location
//   byte_en    byte enables of the lanes touched by a store
//   wdata_algn store data replicated into every lane of its size
//   rdata_ext  selected lane of rword, sign-extended to 32 bits
module data_mem_lane
    import data_mem_pkg::*;
(
    input  access_size_e      size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [3:0]        byte_en,
    output logic [DATA_W-1:0] wdata_algn,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        byte_en    = 4'b1111;
        wdata_algn = wdata;
        rdata_ext  = rword;
        rbyte      = rword[7:0];
        rhalf      = rword[15:0];

        case (addr_lo)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

        case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_algn = {4{wdata[7:0]}};
                rdata_ext  = {{24{rbyte[7]}}, rbyte};
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_algn = {2{wdata[15:0]}};
                rdata_ext  = {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_algn = wdata;
                rdata_ext  = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// data_mem -- word-organised data memory with byte/half/word access.
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset, overrides a simultaneous store
//   bus   data_mem_if slave modport (addr, MemWrite, MemRead,
//         HalfOperation, ByteOperation, data_write, data_read)
// Loads are combinational; stores update only the selected lanes.
// Optional build macro: DATA_MEM_PRELOAD_EN -- reset loads words 0 and 1
// with PRELOAD_WORD0/1 instead of clearing them.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    access_size_e      size;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rword;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] wdata_algn;
    logic [DATA_W-1:0] rdata_ext;

    // Upper address bits only alias the array; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:IDX_W+2];

    assign size    = decode_size(bus.ByteOperation, bus.HalfOperation);
    assign idx     = bus.addr[IDX_W+1:2];
    assign rword   = mem_q[idx];
    assign be_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

    data_mem_lane u_lane (
        .size       (size),
        .addr_lo    (bus.addr[1:0]),
        .wdata      (bus.data_write),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_algn (wdata_algn),
        .rdata_ext  (rdata_ext)
    );

    always_comb begin
        mem_d = mem_q;
        if (bus.MemWrite) begin
            mem_d[idx] = (rword & ~be_mask) | (wdata_algn & be_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef DATA_MEM_PRELOAD_EN
            mem_q[0] <= PRELOAD_WORD0;
            mem_q[1] <= PRELOAD_WORD1;
`else
`endif
        end else begin
            mem_q <= mem_d;
        end
    end

    // No bypass: a load in the same cycle as a store sees the old word.
    assign bus.data_read = bus.MemRead ? rdata_ext : '0;

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;
    import data_mem_pkg::*;

    localparam int DEPTH = 64;

`ifdef DATA_MEM_PRELOAD_EN
    localparam logic [31:0] W0_RST = 32'h807F_0201;
`else
    localparam logic [31:0] W0_RST = 32'h0000_0000;
`endif

    typedef struct {
        logic        rst;
        logic        we;
        logic        re;
        logic        half;
        logic        byte_op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    data_mem_if bus ();

    data_mem #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic re, input logic half,
                         input logic bo, input logic [31:0] addr, input logic [31:0] wd);
        rst               = r;
        bus.MemWrite      = we;
        bus.MemRead       = re;
        bus.HalfOperation = half;
        bus.ByteOperation = bo;
        bus.addr          = addr;
        bus.data_write    = wd;
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic re, input logic half,
                                input logic bo, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.rst = r; v.we = we; v.re = re; v.half = half; v.byte_op = bo;
        v.addr = addr; v.wdata = wd; v.exp = exp; v.name = name;
        return v;
    endfunction

    // Drive one vector after the falling edge, compare before the next rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v.rst, v.we, v.re, v.half, v.byte_op, v.addr, v.wdata);
        #1;
        check(v.name, bus.data_read, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        //          rst we re hf by addr       wdata          expected
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'd0,   32'h0,         32'h0000_0000, "reset_rd_off"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd0,   32'h0,         W0_RST,        "word0_after_rst"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd12,  32'h0,         32'h0000_0000, "word12_after_rst"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'd12,  32'hFF00_FF00, 32'h0000_0000, "word_st_pre_edge"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd12,  32'h0,         32'hFF00_FF00, "word_ld_12"));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'd12,  32'h0000_00FF, 32'h0000_0000, "byte_st_12"));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'd13,  32'h0000_0000, 32'h0000_0000, "byte_st_13"));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'd14,  32'h0000_00FF, 32'h0000_0000, "byte_st_14"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd12,  32'h0,         32'hFFFF_00FF, "word_after_bytes"));
        vecs.push_back(mk(0, 0, 1, 0, 1, 32'd12,  32'h0,         32'hFFFF_FFFF, "byte_ld_12"));
        vecs.push_back(mk(0, 0, 1, 0, 1, 32'd13,  32'h0,         32'h0000_0000, "byte_ld_13"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'd14,  32'h0,         32'hFFFF_FFFF, "byte_prio_ld_14"));
        vecs.push_back(mk(0, 0, 1, 0, 1, 32'd15,  32'h0,         32'hFFFF_FFFF, "byte_ld_15"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'd12,  32'h0,         32'h0000_00FF, "half_ld_12"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'd13,  32'h0,         32'h0000_00FF, "half_ld_13"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'd14,  32'h0,         32'hFFFF_FFFF, "half_ld_14"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd15,  32'h0,         32'hFFFF_00FF, "word_ld_15"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'd18,  32'h0000_ABCD, 32'h0000_0000, "half_st_18"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd16,  32'h0,         32'hABCD_0000, "word_ld_16"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'd16,  32'h0,         32'h0000_0000, "read_off_16"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'd19,  32'h0,         32'hFFFF_ABCD, "half_ld_19"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'd16,  32'hFFFF_8001, 32'h0000_0000, "half_st_16"));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'd17,  32'h1234_5666, 32'h0000_0000, "byte_st_17"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd16,  32'h0,         32'hABCD_6601, "word_ld_16b"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'd268, 32'h1234_5678, 32'h0000_0000, "alias_st_268"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'd12,  32'h0,         32'h1234_5678, "alias_ld_12"));
        vecs.push_back(mk(0, 0, 1, 0, 1, 32'd271, 32'h0,         32'h0000_0012, "alias_byte_271"));

        foreach (vecs[i]) apply(vecs[i]);

        // Load and store in the same cycle: old word before the edge, new after.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd20, 32'h55AA_55AA);
        #1 check("rw_same_pre", bus.data_read, 32'h0000_0000);
        @(posedge clk);
        #1 check("rw_same_post", bus.data_read, 32'h55AA_55AA);
        @(negedge clk);
        bus.MemWrite = 1'b0;
        #1 check("rw_same_hold", bus.data_read, 32'h55AA_55AA);

        // Reset beats a simultaneous store; read stays live during reset.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd16, 32'hDEAD_BEEF);
        #1 check("rst_st_pre", bus.data_read, 32'hABCD_6601);
        @(posedge clk);
        #1 check("rst_st_post", bus.data_read, 32'h0000_0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd16, 32'h0);
        #1 check("rst_word16", bus.data_read, 32'h0000_0000);
        @(negedge clk);
        bus.addr = 32'd12;
        #1 check("rst_word12", bus.data_read, 32'h0000_0000);
        @(negedge clk);
        bus.addr = 32'd0;
        #1 check("rst_word0", bus.data_read, W0_RST);

`ifdef DATA_MEM_PRELOAD_EN
        begin
            logic [31:0] pre_exp [4];
            pre_exp[0] = 32'h0000_0001;
            pre_exp[1] = 32'h0000_0002;
            pre_exp[2] = 32'h0000_007F;
            pre_exp[3] = 32'hFFFF_FF80;
            for (int a = 0; a < 4; a++) begin
                @(negedge clk);
                drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0);
                #1 check($sformatf("preload_byte_%0d", a), bus.data_read, pre_exp[a]);
            end
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
            #1 check("preload_half_4", bus.data_read, 32'h0000_1234);
            @(negedge clk);
            bus.addr = 32'd6;
            #1 check("preload_half_6", bus.data_read, 32'hFFFF_F00D);
        end
`else
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
        #1 check("no_preload_word1", bus.data_read, 32'h0000_0000);
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
